hadamard_sum_accumulator: RTL and testbench
===========================================

Name: hadamard_sum_accumulator

Overview:
- Sits directly downstream of hadamard_product_unit and consumes its SIZE element-wise products (kernel × patch).
- Reduces the products to one sum per beat through a pipelined adder tree.
- Accumulates beats across input channels until a beat tagged last, then emits one convolution output value per window.
- Valid/ready handshake on both sides; the whole pipeline stalls under output backpressure.

Parameters:
- WIDTH, 32, bit width of each product, internal sum and output (two's complement).
- SIZE, 9, number of products per beat (elements of the kernel window). The tree is specified for SIZE=9.
- CNT_W, 8, width of the per-window beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a product beat is presented.
- in_ready  output  1  block can accept a beat this cycle.
- in_last  input  1  beat is the final channel of the current window.
- prods  input  [SIZE-1:0][WIDTH-1:0]  products from hadamard_product_unit res.
- out_valid  output  1  out_sum and out_beats are valid.
- out_ready  input  1  consumer accepts the output.
- out_sum  output  WIDTH  accumulated window sum.
- out_beats  output  CNT_W  number of beats summed into out_sum.

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block has one clock, clk.
- Reset values: in_ready=1 (combinational, see below); out_valid=0; out_sum=0; out_beats=0. All stage valids, the accumulator and the beat counter also reset to 0.
- Global advance: en = !out_valid || out_ready. in_ready = en. All pipeline registers update only when en=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready. A stage captures valid=0 when nothing is accepted (bubble).
- Adder tree, one register stage each, with valid and last carried alongside the data:
  - S1: 9→5 (4 pairwise sums, p8 passed through).
  - S2: 5→3.
  - S3: 3→2.
  - S4: 2→1.
- Accumulate stage, when en && S4.valid:
  - Not last: acc <= acc + s4; cnt <= cnt+1.
  - Last: out_sum <= acc + s4; out_beats <= cnt+1; out_valid <= 1; acc <= 0; cnt <= 0.
- Output retire: when en && out_valid && out_ready and no new result is produced, out_valid <= 0.
- Simultaneous output handshake and new result in the same cycle: out_valid stays 1 and the new data is loaded; no bubble.
- Output stability: while out_valid && !out_ready, out_sum and out_beats are held stable and in_ready=0.
- Latency: a last beat accepted at cycle t gives out_valid=1 at cycle t+5 when no stall occurs. Throughput is 1 beat/cycle while out_ready=1.
- Arithmetic: all additions wrap modulo 2^WIDTH; there is no overflow flag.
- Beat counter: cnt saturates at 2^CNT_W-1 and does not wrap.
- Back-to-back windows: the beat following a last beat starts a new window with acc=0. A beat with in_last=1 alone forms a 1-beat window.
- Reset mid-window discards the partial accumulation and all in-flight beats.

Optional Feature:
- Macro: HADAMARD_SUM_RELU_EN.
- Defined: when a result is loaded, out_sum <= (sum[WIDTH-1] ? 0 : sum), i.e. ReLU applied to the final window sum only. The accumulator itself stays signed.
- Undefined: out_sum is the raw wrapped sum.
- Latency is identical in both builds.

Test Plan:
- Single beat, prods = 1..9, in_last=1, out_ready=1 → out_valid high 5 cycles later, out_sum=45, out_beats=1, then out_valid drops.
- Three consecutive beats, all prods=1, last on the third → exactly one output: out_sum=27, out_beats=3.
- out_ready held 0, two 1-beat windows (sums 45 and 90) sent back-to-back:
  - in_ready goes 0 once the first result is loaded.
  - out_sum holds 45 stably.
  - Raising out_ready yields 45 then 90 with no loss or duplication.
- Wrap/negative case, single beat with prods = 0x7FFFFFFF, 1, and zeros:
  - No macro: out_sum=0x80000000.
  - With macro: out_sum=0.
  - All prods = 0xFFFFFFFF: out_sum=0xFFFFFFF7 without the macro, 0 with it.
- Assert rst_n low after 2 of 3 beats of a window → out_valid=0 immediately. After release, a new 1-beat window of all 2s gives out_sum=18, out_beats=1 with no stale contribution.
- Continuous stream of 1-beat windows with out_ready=1 → one result per cycle after the 5-cycle fill; in_ready stays 1 throughout.

Source files
------------

// File: rtl/hadamard_sum_accumulator.sv
// Purpose: sums the SIZE=9 products of each beat in a 4-stage adder tree and accumulates beats into one sum per window.
// Latency: a last beat accepted at cycle t gives out_valid at t+5; throughput is 1 beat/cycle.
// Backpressure: when out_valid && !out_ready, every stage freezes and in_ready drops (one global enable, no skid buffer).
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_last   product beat handshake; in_last marks the final channel of a window
//   prods[SIZE]                 element-wise products from hadamard_product_unit
//   out_valid/out_ready         result handshake
//   out_sum, out_beats          window sum (wraps modulo 2^WIDTH) and beat count (saturating)
// Optional build macro: HADAMARD_SUM_RELU_EN clamps a negative final window sum to zero.
module hadamard_sum_accumulator #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 9,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [SIZE-1:0][WIDTH-1:0]  prods,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_sum,
    output logic [CNT_W-1:0]            out_beats
);

    // Control tag carried alongside the data through every tree stage.
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    logic                en;
    tag_t                s1_tag, s2_tag, s3_tag, s4_tag;
    logic [4:0][WIDTH-1:0] s1_dat;
    logic [2:0][WIDTH-1:0] s2_dat;
    logic [1:0][WIDTH-1:0] s3_dat;
    logic [WIDTH-1:0]    s4_dat;

    logic [WIDTH-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    sum_total;
    logic [WIDTH-1:0]    result;
    logic [CNT_W-1:0]    cnt_inc;

    // The only place a stall can originate is a held output, so one enable covers the whole pipe.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Adder tree: 9 -> 5 -> 3 -> 2 -> 1, one register per level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag <= '0;
            s2_tag <= '0;
            s3_tag <= '0;
            s4_tag <= '0;
            s1_dat <= '0;
            s2_dat <= '0;
            s3_dat <= '0;
            s4_dat <= '0;
        end else if (en) begin
            // last is gated with valid so a bubble can never close a window.
            s1_tag    <= '{vld: in_valid, last: in_valid && in_last};
            s1_dat[0] <= prods[0] + prods[1];
            s1_dat[1] <= prods[2] + prods[3];
            s1_dat[2] <= prods[4] + prods[5];
            s1_dat[3] <= prods[6] + prods[7];
            s1_dat[4] <= prods[8];

            s2_tag    <= s1_tag;
            s2_dat[0] <= s1_dat[0] + s1_dat[1];
            s2_dat[1] <= s1_dat[2] + s1_dat[3];
            s2_dat[2] <= s1_dat[4];

            s3_tag    <= s2_tag;
            s3_dat[0] <= s2_dat[0] + s2_dat[1];
            s3_dat[1] <= s2_dat[2];

            s4_tag    <= s3_tag;
            s4_dat    <= s3_dat[0] + s3_dat[1];
        end
    end

    // Accumulator input and saturating beat count.
    always_comb begin
        sum_total = acc + s4_dat;
        cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
`ifdef HADAMARD_SUM_RELU_EN
        // Clamp only the emitted value; the running accumulator stays signed.
        result    = sum_total[WIDTH-1] ? '0 : sum_total;
`else
        result    = sum_total;
`endif
    end

    // Accumulate stage and output register. A new result loaded in the same cycle
    // as the old one retires keeps out_valid high, so back-to-back windows see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
        end else if (en) begin
            out_valid <= s4_tag.vld && s4_tag.last;
            if (s4_tag.vld && s4_tag.last) begin
                out_sum   <= result;
                out_beats <= cnt_inc;
                acc       <= '0;
                cnt       <= '0;
            end else if (s4_tag.vld) begin
                acc <= sum_total;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_hadamard_sum_accumulator.sv
// Purpose: self-checking bench for hadamard_sum_accumulator against a window-level sum model.
// Latency: inputs driven 1 time unit after the rising edge, handshakes sampled on the falling edge.
// Backpressure: out_ready is driven per scenario, including a randomly toggling consumer.
module tb_hadamard_sum_accumulator;

    localparam int WIDTH = 32;
    localparam int SIZE  = 9;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [SIZE-1:0][WIDTH-1:0] prods_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    prods_t           prods = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int stalls = 0;
    bit done = 1'b0;

    hadamard_sum_accumulator #(.WIDTH(WIDTH), .SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .prods     (prods),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output collector: a result is consumed when valid && ready hold through the edge.
    logic [WIDTH-1:0] got_sum[$];
    logic [CNT_W-1:0] got_beats[$];
    int               got_cyc[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_sum.push_back(out_sum);
            got_beats.push_back(out_beats);
            got_cyc.push_back(cyc);
        end
    end

    // Reference model: a window's result is the plain sum of every product of every
    // beat, truncated to WIDTH bits, with the beat count capped at CNT_MAX.
    longint unsigned  m_acc = 0;
    int               m_n = 0;
    logic [WIDTH-1:0] exp_sum[$];
    logic [CNT_W-1:0] exp_beats[$];

    function automatic void model_beat(input prods_t p, input logic last);
        logic [WIDTH-1:0] s;
        for (int i = 0; i < SIZE; i++) m_acc += longint'(p[i]);
        m_n++;
        if (last) begin
            s = m_acc[WIDTH-1:0];
`ifdef HADAMARD_SUM_RELU_EN
            if (s[WIDTH-1]) s = '0;
`endif
            exp_sum.push_back(s);
            exp_beats.push_back(CNT_W'((m_n > CNT_MAX) ? CNT_MAX : m_n));
            m_acc = 0;
            m_n   = 0;
        end
    endfunction

    task automatic clear_queues();
        got_sum.delete();
        got_beats.delete();
        got_cyc.delete();
        exp_sum.delete();
        exp_beats.delete();
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic drive(input prods_t p, input logic last);
        int n = 0;
        in_valid = 1'b1;
        prods    = p;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                errors++;
                checks++;
                $display("FAIL drive_timeout: beat not accepted after %0d cycles, need acceptance", n);
                break;
            end
        end
        stalls += n;
        acc_cyc = cyc;
        model_beat(p, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (got_sum.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (got_sum.size() < n) begin
            errors++;
            checks++;
            $display("FAIL wait_out: got %0d results, need %0d", got_sum.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h need 0", out_sum); end
        checks++; if (out_beats !== '0) begin errors++; $display("FAIL reset_out_beats: got %0d need 0", out_beats); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        prods_t p;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++) p[i] = WIDTH'(i + 1);
        drive(p, 1'b1);
        wait_out(1, 20);
        checks++;
        if (got_sum.size() < 1 || got_sum[0] !== 32'd45 || got_beats[0] !== 8'd1)
            begin errors++; $display("FAIL single_value: got %h/%0d need 45/1", got_sum.size() ? got_sum[0] : 'x, got_beats.size() ? got_beats[0] : 'x); end
        checks++;
        if (got_cyc.size() < 1 || got_cyc[0] - acc_cyc != 5)
            begin errors++; $display("FAIL single_latency: got %0d need 5", got_cyc.size() ? got_cyc[0] - acc_cyc : -1); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || got_sum.size() != 1)
            begin errors++; $display("FAIL single_drop: out_valid=%b results=%0d need 0/1", out_valid, got_sum.size()); end
    endtask

    task automatic test_multi_beat();
        prods_t p;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++) p[i] = WIDTH'(1);
        drive(p, 1'b0);
        drive(p, 1'b0);
        drive(p, 1'b1);
        wait_out(1, 20);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_sum.size() != 1 || got_sum[0] !== 32'd27 || got_beats[0] !== 8'd3)
            begin errors++; $display("FAIL multi_beat: got n=%0d %h/%0d need n=1 27/3", got_sum.size(), got_sum.size() ? got_sum[0] : 'x, got_beats.size() ? got_beats[0] : 'x); end
    endtask

    task automatic test_backpressure();
        prods_t p1, p2;
        int k = 0;
        clear_queues();
        out_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            p1[i] = WIDTH'(i + 1);
            p2[i] = WIDTH'(2 * (i + 1));
        end
        drive(p1, 1'b1);
        drive(p2, 1'b1);
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b need 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b need 0", in_ready); end
        checks++; if (out_sum !== 32'd45) begin errors++; $display("FAIL bp_first_sum: got %0d need 45", out_sum); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd45 || out_beats !== 8'd1)
            begin errors++; $display("FAIL bp_hold: got v=%b %0d/%0d need 1 45/1", out_valid, out_sum, out_beats); end
        out_ready = 1'b1;
        wait_out(2, 20);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_sum.size() != 2) begin errors++; $display("FAIL bp_count: got %0d results need 2", got_sum.size()); end
        for (int i = 0; i < exp_sum.size() && i < got_sum.size(); i++) begin
            checks++;
            if (got_sum[i] !== exp_sum[i] || got_beats[i] !== exp_beats[i])
                begin errors++; $display("FAIL bp_result[%0d]: got %0d/%0d need %0d/%0d", i, got_sum[i], got_beats[i], exp_sum[i], exp_beats[i]); end
        end
    endtask

    task automatic test_wrap();
        prods_t p;
        logic [WIDTH-1:0] e0, e1;
`ifdef HADAMARD_SUM_RELU_EN
        e0 = 32'h0;
        e1 = 32'h0;
`else
        e0 = 32'h8000_0000;
        e1 = 32'hFFFF_FFF7;
`endif
        clear_queues();
        out_ready = 1'b1;
        p = '0;
        p[0] = 32'h7FFF_FFFF;
        p[1] = 32'h1;
        drive(p, 1'b1);
        for (int i = 0; i < SIZE; i++) p[i] = 32'hFFFF_FFFF;
        drive(p, 1'b1);
        wait_out(2, 20);
        checks++;
        if (got_sum.size() < 1 || got_sum[0] !== e0) begin errors++; $display("FAIL wrap_pos: got %h need %h", got_sum.size() ? got_sum[0] : 'x, e0); end
        checks++;
        if (got_sum.size() < 2 || got_sum[1] !== e1) begin errors++; $display("FAIL wrap_neg: got %h need %h", got_sum.size() > 1 ? got_sum[1] : 'x, e1); end
    endtask

    task automatic test_reset_mid_window();
        prods_t p;
        int k = 0;
        clear_queues();
        out_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) p[i] = WIDTH'($urandom_range(1, 1000));
        drive(p, 1'b1);
        drive(p, 1'b0);
        drive(p, 1'b0);
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_beats !== '0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL mid_reset: got v=%b sum=%h beats=%0d rdy=%b need 0/0/0/1", out_valid, out_sum, out_beats, in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_acc = 0;
        m_n   = 0;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++) p[i] = WIDTH'(2);
        drive(p, 1'b1);
        wait_out(1, 20);
        checks++;
        if (got_sum.size() < 1 || got_sum[0] !== 32'd18 || got_beats[0] !== 8'd1)
            begin errors++; $display("FAIL mid_reset_after: got %0d/%0d need 18/1", got_sum.size() ? got_sum[0] : 'x, got_beats.size() ? got_beats[0] : 'x); end
    endtask

    task automatic test_back_to_back();
        prods_t p;
        clear_queues();
        out_ready = 1'b1;
        stalls = 0;
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < SIZE; i++) p[i] = $urandom;
            drive(p, 1'b1);
        end
        wait_out(20, 40);
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL b2b_in_ready: got %0d stall cycles need 0", stalls); end
        for (int i = 0; i < exp_sum.size() && i < got_sum.size(); i++) begin
            checks++;
            if (got_sum[i] !== exp_sum[i] || got_beats[i] !== exp_beats[i] || (i > 0 && got_cyc[i] - got_cyc[i-1] != 1))
                begin errors++; $display("FAIL b2b_result[%0d]: got %h/%0d need %h/%0d", i, got_sum[i], got_beats[i], exp_sum[i], exp_beats[i]); end
        end
    endtask

    task automatic test_saturation();
        prods_t p;
        clear_queues();
        out_ready = 1'b1;
        for (int b = 0; b < 260; b++) begin
            for (int i = 0; i < SIZE; i++) p[i] = WIDTH'($urandom_range(0, 100));
            drive(p, b == 259);
        end
        wait_out(1, 20);
        checks++;
        if (got_sum.size() < 1 || got_sum[0] !== exp_sum[0] || got_beats[0] !== 8'd255)
            begin errors++; $display("FAIL saturation: got %h/%0d need %h/255", got_sum.size() ? got_sum[0] : 'x, got_beats.size() ? got_beats[0] : 'x, exp_sum[0]); end
    endtask

    task automatic test_random();
        prods_t p;
        int nb;
        clear_queues();
        done = 1'b0;
        fork
            begin
                for (int w = 0; w < 30; w++) begin
                    nb = $urandom_range(1, 4);
                    for (int b = 0; b < nb; b++) begin
                        for (int i = 0; i < SIZE; i++) p[i] = $urandom;
                        drive(p, b == nb - 1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_out(30, 100);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_sum.size() != 30) begin errors++; $display("FAIL random_count: got %0d need 30", got_sum.size()); end
        for (int i = 0; i < exp_sum.size() && i < got_sum.size(); i++) begin
            checks++;
            if (got_sum[i] !== exp_sum[i] || got_beats[i] !== exp_beats[i])
                begin errors++; $display("FAIL random_result[%0d]: got %h/%0d need %h/%0d", i, got_sum[i], got_beats[i], exp_sum[i], exp_beats[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_wrap();
        test_reset_mid_window();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
